// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: M-stage memory access controller.
// It turns the M-stage load or store into a req/ack transaction on a shared,
// variable-latency 64-bit data memory port. It builds byte strobes and
// lane-aligned store data, and it sign- or zero-extends load data. It stalls
// the upstream pipeline and bubbles MW until the access completes, times out,
// or is rejected as misaligned.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   MemRead_M/MemWrite_M M-stage load/store (both high -> store)
//   Funct3_M            size/sign: b,h,w,d,bu,hu,wu
//   ALUResult_M         effective byte address
//   WriteData_M         right-aligned store operand
//   dmem_req/we/addr/wstrb/wdata  registered request to memory
//   dmem_ack, dmem_rdata          memory response
//   ReadData_M          registered, extended load result
//   Stall_M, Flush_W    freeze F/D/E + EM, bubble MW
//   MisalignExc_M       combinational misalign flag (IDLE only)
//   BusErr_M            one-cycle pulse on timeout
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  Funct3_M,
  input  logic [63:0] ALUResult_M,
  input  logic [63:0] WriteData_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_wstrb,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] ReadData_M,
  output logic        Stall_M,
  output logic        Flush_W,
  output logic        MisalignExc_M,
  output logic        BusErr_M
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q, off_q;
  logic             ld_q;

  logic       access, is_store, misalign;
  logic [2:0] off;
  logic [7:0] strb;
  logic       stall, mis_exc, start, ack_hit, tmo;
  logic [63:0] lane, ext;

  // Request decode: the size comes from Funct3_M[1:0], and alignment is
  // judged against that size.
  always_comb begin
    off      = ALUResult_M[2:0];
    access   = MemRead_M | MemWrite_M;
    is_store = MemWrite_M;
    misalign = 1'b0;
    strb     = 8'hFF;
    case (Funct3_M[1:0])
      2'd0: begin misalign = 1'b0;       strb = 8'h01 << off; end
      2'd1: begin misalign = off[0];     strb = 8'h03 << off; end
      2'd2: begin misalign = |off[1:0];  strb = 8'h0F << off; end
      default: begin misalign = |off;    strb = 8'hFF;        end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mis_exc  = 1'b0;
    start    = 1'b0;
    ack_hit  = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misalign) begin
            mis_exc = 1'b1;
          end else begin
            stall    = 1'b1;
            start    = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          ack_hit  = 1'b1;
          state_nx = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Stall_M       = stall;
  assign Flush_W       = stall;
  assign MisalignExc_M = mis_exc;

  // Load extension uses the offset and size captured at request time, so it
  // does not depend on the inputs staying frozen.
  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{56{lane[7]}},  lane[7:0]};
      3'b001:  ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ext = {{32{lane[31]}}, lane[31:0]};
      3'b100:  ext = {56'd0, lane[7:0]};
      3'b101:  ext = {48'd0, lane[15:0]};
      3'b110:  ext = {32'd0, lane[31:0]};
      default: ext = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wstrb <= 8'd0;
      dmem_wdata <= 64'd0;
      ReadData_M <= 64'd0;
      BusErr_M   <= 1'b0;
      cnt        <= '0;
      f3_q       <= 3'd0;
      off_q      <= 3'd0;
      ld_q       <= 1'b0;
    end else begin
      BusErr_M <= 1'b0;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {ALUResult_M[63:3], 3'b000};
        dmem_wstrb <= is_store ? strb : 8'd0;
        dmem_wdata <= WriteData_M << {off, 3'b000};
        f3_q       <= Funct3_M;
        off_q      <= off;
        ld_q       <= ~is_store;
        cnt        <= '0;
      end else if (ack_hit) begin
        dmem_req <= 1'b0;
        if (ld_q) ReadData_M <= ext;
      end else if (tmo) begin
        dmem_req   <= 1'b0;
        ReadData_M <= 64'd0;
        BusErr_M   <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl. A transaction-level model predicts every
// output on every cycle. The prediction is based on the position of the cycle
// inside the access (issue, wait cycles, done) and on arithmetic strobe,
// alignment and extension rules. Directed cases pin the model with literals.
module tb_dmem_access_ctrl;
  localparam int TO = 16;

  logic        clk, rst;
  logic        MemRead_M, MemWrite_M;
  logic [2:0]  Funct3_M;
  logic [63:0] ALUResult_M, WriteData_M;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata, ReadData_M;
  logic        Stall_M, Flush_W, MisalignExc_M, BusErr_M;

  dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .Funct3_M(Funct3_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ReadData_M(ReadData_M),
    .Stall_M(Stall_M), .Flush_W(Flush_W), .MisalignExc_M(MisalignExc_M),
    .BusErr_M(BusErr_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // expected values for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_mis, exp_req, exp_berr, exp_bus, exp_we;
  logic [63:0] exp_rd, exp_addr, exp_wdata;
  logic [7:0]  exp_wstrb;
  logic [63:0] cur_rd = 64'd0;

  logic [63:0] snap_addr, snap_wdata;
  logic [7:0]  snap_wstrb;
  logic        snap_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] bmask(input logic [7:0] s);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] model_ext(input logic [63:0] rd, input logic [2:0] f3,
                                            input logic [2:0] off);
    int nb;
    logic [63:0] v, mask;
    nb = 1 << f3[1:0];
    v = rd >> (8 * off);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & mask;
    if (!f3[2] && nb != 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {63'd0, Stall_M}, {63'd0, exp_stall});
      chk("flush", {63'd0, Flush_W}, {63'd0, exp_stall});
      chk("misalign", {63'd0, MisalignExc_M}, {63'd0, exp_mis});
      chk("req", {63'd0, dmem_req}, {63'd0, exp_req});
      chk("buserr", {63'd0, BusErr_M}, {63'd0, exp_berr});
      chk("readdata", ReadData_M, exp_rd);
      if (exp_bus) begin
        chk("addr", dmem_addr, exp_addr);
        chk("we", {63'd0, dmem_we}, {63'd0, exp_we});
        if (exp_we) begin
          chk("wstrb", {56'd0, dmem_wstrb}, {56'd0, exp_wstrb});
          chk("wdata", dmem_wdata & bmask(exp_wstrb), exp_wdata & bmask(exp_wstrb));
        end
      end
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0; exp_berr = 1'b0;
    exp_bus = 1'b0; exp_rd = cur_rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MemRead_M = 1'b0; MemWrite_M = 1'b0;
      dmem_ack = ($urandom_range(0, 3) == 0);   // stray acks must be ignored
      dmem_rdata = {$urandom(), $urandom()};
      set_idle_exp();
      @(negedge clk);
    end
  endtask

  // dly: ack in WAIT cycle dly+1; dly >= TO means no ack at all
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] rdata, input int dly,
                         input logic use_lit, input logic [63:0] lit_rd,
                         input int lit_stall);
    int nb, w, stalls;
    logic [2:0] off;
    logic mis, to;
    nb  = 1 << f3[1:0];
    off = addr[2:0];
    mis = (int'(off) % nb) != 0;
    to  = dly >= TO;
    w   = to ? TO : dly + 1;
    stalls = 0;

    @(posedge clk); #1;
    MemRead_M = rd; MemWrite_M = wr; Funct3_M = f3;
    ALUResult_M = addr; WriteData_M = wd;
    dmem_ack = 1'b0; dmem_rdata = {$urandom(), $urandom()};
    set_idle_exp();
    exp_stall = !mis; exp_mis = mis;
    @(negedge clk);
    stalls += int'(Stall_M);

    if (mis) begin
      @(posedge clk); #1;
      MemRead_M = 1'b0; MemWrite_M = 1'b0;
      set_idle_exp();
      @(negedge clk);
    end else begin
      exp_addr  = {addr[63:3], 3'b000};
      exp_we    = wr;
      exp_wstrb = 8'((((16'd1 << nb) - 16'd1) << off));
      exp_wdata = wd << (8 * off);
      for (int k = 1; k <= w; k++) begin
        @(posedge clk); #1;
        dmem_ack   = !to && (k == dly + 1);
        dmem_rdata = dmem_ack ? rdata : {$urandom(), $urandom()};
        exp_stall = 1'b1; exp_req = 1'b1; exp_bus = 1'b1; exp_mis = 1'b0;
        @(negedge clk);
        stalls += int'(Stall_M);
        if (k == 1) begin
          snap_addr = dmem_addr; snap_wdata = dmem_wdata;
          snap_wstrb = dmem_wstrb; snap_we = dmem_we;
        end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (to) cur_rd = 64'd0;
      else if (!wr) cur_rd = model_ext(rdata, f3, off);
      set_idle_exp();
      exp_berr = to;
      @(negedge clk);
      stalls += int'(Stall_M);
      if (use_lit) chk("lit_readdata", ReadData_M, lit_rd);
    end
    if (lit_stall >= 0) chk("lit_stall_cycles", 64'(stalls), 64'(lit_stall));
  endtask

  initial begin
    rst = 1'b1; MemRead_M = 1'b0; MemWrite_M = 1'b0; Funct3_M = 3'd0;
    ALUResult_M = 64'd0; WriteData_M = 64'd0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
    set_idle_exp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_we", {63'd0, dmem_we}, 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    chk("rst_wstrb", {56'd0, dmem_wstrb}, 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_readdata", ReadData_M, 64'd0);
    chk("rst_buserr", {63'd0, BusErr_M}, 64'd0);
    chk("rst_stall", {63'd0, Stall_M}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // lw 0x1004, ack in first WAIT cycle
    run_txn(1'b1, 1'b0, 3'b010, 64'h1004, 64'd0, 64'h80000000_11111111, 0,
            1'b1, 64'hFFFFFFFF_80000000, 2);
    chk("lit_lw_addr", snap_addr, 64'h1000);
    idle(1);
    // sb 0xAB to 0x2003, ack after 3 extra wait cycles
    run_txn(1'b0, 1'b1, 3'b000, 64'h2003, 64'hAB, 64'd0, 3, 1'b0, 64'd0, 5);
    chk("lit_sb_we", {63'd0, snap_we}, 64'd1);
    chk("lit_sb_wstrb", {56'd0, snap_wstrb}, 64'h08);
    chk("lit_sb_lane", {56'd0, snap_wdata[31:24]}, 64'hAB);
    chk("lit_sb_addr", snap_addr, 64'h2000);
    idle(1);
    run_txn(1'b1, 1'b0, 3'b101, 64'h3006, 64'd0, 64'hF00D_0000_0000_0000, 1,
            1'b1, 64'h0000_0000_0000_F00D, 3);
    run_txn(1'b1, 1'b0, 3'b001, 64'h3006, 64'd0, 64'hF00D_0000_0000_0000, 0,
            1'b1, 64'hFFFF_FFFF_FFFF_F00D, 2);
    // misaligned sd
    run_txn(1'b0, 1'b1, 3'b011, 64'h4004, 64'h1234, 64'd0, 0, 1'b0, 64'd0, 0);
    idle(1);
    // ld that never gets an ack
    run_txn(1'b1, 1'b0, 3'b011, 64'h4008, 64'd0, 64'd0, 100,
            1'b1, 64'd0, TO + 1);
    idle(2);

    // reset in the middle of WAIT, then a stray ack
    @(posedge clk); #1;
    MemRead_M = 1'b1; Funct3_M = 3'b011; ALUResult_M = 64'h5000;
    set_idle_exp(); exp_stall = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      set_idle_exp(); exp_stall = 1'b1; exp_req = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b1; MemRead_M = 1'b0;
    cur_rd = 64'd0;
    set_idle_exp();
    #1 chk("rst_mid_wait_req", {63'd0, dmem_req}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1;
    set_idle_exp();
    @(negedge clk);
    idle(3);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      int kind, nb, dly;
      logic [2:0] f3;
      logic [63:0] addr;
      kind = $urandom_range(0, 2);
      f3   = (kind == 0) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      nb   = 1 << f3[1:0];
      addr = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nb - 1);
      dly  = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
      run_txn(kind != 1 ? 1'b1 : 1'b0, kind != 0 ? 1'b1 : 1'b0, f3, addr,
              {$urandom(), $urandom()}, {$urandom(), $urandom()}, dly,
              1'b0, 64'd0, -1);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
